// File: rtl/bin_bcd_seq_if.sv
// Handshake and digit bundle between the arithmetic stage and the
// binary-to-BCD converter. master drives start/wejscie/minus, slave returns
// busy/done/ovf and the four BCD digits cyfra1 (units) .. cyfra4 (thousands).
interface bin_bcd_seq_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] wejscie;
    logic             minus;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       cyfra1;
    logic [3:0]       cyfra2;
    logic [3:0]       cyfra3;
    logic [3:0]       cyfra4;

    modport master (
        output start, wejscie, minus,
        input  busy, done, ovf,
        input  cyfra1, cyfra2, cyfra3, cyfra4
    );

    modport slave (
        input  start, wejscie, minus,
        output busy, done, ovf,
        output cyfra1, cyfra2, cyfra3, cyfra4
    );
endinterface

// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 7-seg decoders.
// Ports: CLOCK_50, RESET (async, active-high), bus (slave: start/wejscie/minus in;
// busy/done/ovf/cyfra1..cyfra4 out). Digits hold until the next conversion ends.
module bin_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    bin_bcd_seq_if.slave bus
);
    localparam int AW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sr;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    adj;
    logic [CW-1:0]    cnt;
    logic             neg;

    // Correct every nibble in parallel before the shift, so a digit >= 5
    // carries into the next nibble instead of becoming a non-BCD code.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = SHIFT;
            SHIFT:   if (cnt == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sr         <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.cyfra1 <= 4'd0;
            bus.cyfra2 <= 4'd0;
            bus.cyfra3 <= 4'd0;
            bus.cyfra4 <= 4'd0;
        end else begin
            // Registered from the next state so busy covers SHIFT..DONE exactly.
            bus.busy <= (state_n != IDLE);
            bus.done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr  <= bus.wejscie;
                        neg <= bus.minus;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    {acc, sr} <= {adj, sr} << 1;
                    cnt       <= cnt + CW'(1);
                end
                DONE: begin
                    bus.cyfra1 <= acc[3:0];
                    bus.cyfra2 <= acc[7:4];
                    bus.cyfra3 <= acc[11:8];
                    bus.cyfra4 <= neg ? 4'd10 : acc[15:12];
                    bus.ovf    <= neg & (acc[15:12] != 4'd0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: reset, basic, extremes, negative/ovf,
// start-while-busy and abort scenarios with hand-computed BCD results.
module tb_bin_bcd_seq;
    logic CLOCK_50;
    logic RESET;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    bin_bcd_seq_if #(.WIDTH(10)) bus ();

    bin_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc++;

    wire [15:0] dig = {bus.cyfra4, bus.cyfra3, bus.cyfra2, bus.cyfra1};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; start is accepted at the next rising edge.
    // lat = rising edges after the accepting edge until done is seen.
    task automatic conv(input logic [9:0] w, input logic m,
                        output int lat, output int bc);
        bus.wejscie = w;
        bus.minus   = m;
        bus.start   = 1'b1;
        lat = -1;
        bc  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) bus.start = 1'b0;
            if (bus.busy) bc++;
            if (bus.done) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLOCK_50);
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    logic [15:0] expq [3];
    int lat, bc, t1, t2, nd, dbl, n;
    logic prev;

    initial begin
        expq = '{16'h0100, 16'h0112, 16'h0124};
        RESET       = 1'b0;
        bus.start   = 1'b0;
        bus.wejscie = '0;
        bus.minus   = 1'b0;

        #3 RESET = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_dig", dig, 16'h0000);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        conv(10'd961, 1'b0, lat, bc);
        chk("b961_lat", lat, 11);
        chk("b961_busy", bc, 11);
        chk("b961_dig", dig, 16'h0961);
        chk("b961_ovf", bus.ovf, 0);
        @(negedge CLOCK_50);
        chk("b961_pulse", bus.done, 0);
        chk("b961_hold", dig, 16'h0961);

        conv(10'd0, 1'b0, lat, bc);
        t1 = cyc;
        chk("z_lat", lat, 11);
        chk("z_dig", dig, 16'h0000);
        conv(10'd1023, 1'b0, lat, bc);
        t2 = cyc;
        chk("max_dig", dig, 16'h1023);
        chk("max_gap", t2 - t1, 12);

        conv(10'd5, 1'b1, lat, bc);
        chk("n5_lat", lat, 11);
        chk("n5_dig", dig, 16'hA005);
        chk("n5_ovf", bus.ovf, 0);
        conv(10'd1000, 1'b1, lat, bc);
        chk("n1000_dig", dig, 16'hA000);
        chk("n1000_ovf", bus.ovf, 1);
        @(negedge CLOCK_50);
        chk("n1000_hold", bus.ovf, 1);

        #2 RESET = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_ovf", bus.ovf, 0);
        chk("arst_dig", dig, 16'h0000);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        bus.start = 1'b1;
        bus.minus = 1'b0;
        nd   = 0;
        dbl  = 0;
        prev = 1'b0;
        for (int i = 0; i < 37; i++) begin
            if (i > 0) begin
                @(negedge CLOCK_50);
                if (prev && bus.done) dbl++;
                prev = bus.done;
                if (bus.done) begin
                    if (nd < 3) chk("bz_dig", dig, expq[nd]);
                    nd++;
                end
            end
            bus.wejscie = 10'(100 + i);
        end
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        chk("bz_ndone", nd, 3);
        chk("bz_double", dbl, 0);
        wait_done(n);
        chk("bz_tail_to", n != -1, 1);
        chk("bz_tail_dig", dig, 16'h0136);
        @(negedge CLOCK_50);

        bus.wejscie = 10'd777;
        bus.start   = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk("ab_busy_pre", bus.busy, 1);
        #2 RESET = 1'b1;
        #1;
        chk("ab_busy", bus.busy, 0);
        chk("ab_dig", dig, 16'h0000);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (bus.done) nd++;
        end
        chk("ab_nodone", nd, 0);
        chk("ab_dig_after", dig, 16'h0000);

        conv(10'd42, 1'b0, lat, bc);
        chk("c42_lat", lat, 11);
        chk("c42_dig", dig, 16'h0042);
        chk("c42_ovf", bus.ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
